// File: rtl/jk_drive_sequencer.sv
// Drives J/K excitation into a bank of W JK flip-flops, waits for it to settle and verifies q_fb.
// Optional macro JK_TOGGLE_DRIVE_EN selects toggle excitation (J=K=1) for changing bits.
module jk_drive_sequencer #(
    parameter int unsigned W             = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned MAX_RETRY     = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_target,
    input  logic [W-1:0] q_fb,
    output logic [W-1:0] j,
    output logic [W-1:0] k,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] mismatch
);

    typedef enum logic [1:0] {StIdle, StDrive, StSettle, StCheck} state_e;

    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] MaxRetry   = 3'(MAX_RETRY);

    state_e         state_q, state_d;
    logic [W-1:0]   target_q, target_d;
    logic [2:0]     retry_q, retry_d;
    logic [3:0]     settle_q, settle_d;
    logic [W-1:0]   j_q, j_d, k_q, k_d;
    logic           done_q, done_d, err_q, err_d;
    logic [W-1:0]   mismatch_q, mismatch_d;

    logic [W-1:0]   exc_t, exc_j, exc_k;

    // In IDLE the excitation is computed against the incoming request, otherwise the latched target
    assign exc_t = (state_q == StIdle) ? req_target : target_q;

`ifdef JK_TOGGLE_DRIVE_EN
    assign exc_j = q_fb ^ exc_t;
    assign exc_k = q_fb ^ exc_t;
`else
    assign exc_j = exc_t & ~q_fb;
    assign exc_k = q_fb & ~exc_t;
`endif

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        retry_d    = retry_q;
        settle_d   = settle_q;
        j_d        = '0;
        k_d        = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        mismatch_d = mismatch_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    target_d   = req_target;
                    retry_d    = '0;
                    mismatch_d = '0;
                    j_d        = exc_j;
                    k_d        = exc_k;
                    state_d    = StDrive;
                end
            end
            StDrive: begin
                settle_d = SettleLoad;
                state_d  = StSettle;
            end
            StSettle: begin
                if (settle_q == 4'd0) begin
                    state_d = StCheck;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            StCheck: begin
                if (q_fb == target_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (retry_q < MaxRetry) begin
                    retry_d = retry_q + 3'd1;
                    j_d     = exc_j;
                    k_d     = exc_k;
                    state_d = StDrive;
                end else begin
                    err_d      = 1'b1;
                    mismatch_d = q_fb ^ target_q;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            target_q   <= '0;
            retry_q    <= '0;
            settle_q   <= '0;
            j_q        <= '0;
            k_q        <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mismatch_q <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            retry_q    <= retry_d;
            settle_q   <= settle_d;
            j_q        <= j_d;
            k_q        <= k_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign j         = j_q;
    assign k         = k_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Scoreboard bench for jk_drive_sequencer driving a behavioural JK bank model.
module tb_jk_drive_sequencer;

`ifdef JK_TOGGLE_DRIVE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_target = 4'b0;
    logic [3:0] q_fb;
    logic       req_ready, busy, done, err;
    logic [3:0] j, k, mismatch;

    always #5 clk = ~clk;

    jk_drive_sequencer #(
        .W             (4),
        .SETTLE_CYCLES (2),
        .MAX_RETRY     (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .q_fb       (q_fb),
        .j          (j),
        .k          (k),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mismatch   (mismatch)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Behavioural JK bank; stuck forces bits of q_fb to 0
    logic [3:0] q_bank = 4'b0;
    logic [3:0] stuck = 4'b0;
    logic [3:0] load_val = 4'b0;
    logic       bank_load = 1'b0;

    always @(posedge clk) begin
        if (bank_load) begin
            q_bank <= load_val;
        end else begin
            for (int i = 0; i < 4; i++) begin
                case ({j[i], k[i]})
                    2'b10: q_bank[i] <= 1'b1;
                    2'b01: q_bank[i] <= 1'b0;
                    2'b11: q_bank[i] <= ~q_bank[i];
                    default: ;
                endcase
            end
        end
    end
    assign q_fb = q_bank & ~stuck;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [3:0] j; logic [3:0] k; } drv_t;
    typedef struct { bit is_err; logic [3:0] mism; int lat; int busy; } res_t;
    drv_t drv_q[$];
    res_t res_q[$];

    int acc_cyc = 0;
    int busy_cnt = 0;

    // Monitor: pops expectations whenever the DUT presents a drive pulse or a result
    always @(negedge clk) begin
        drv_t d;
        res_t r;
        if (reset_n) begin
            if (busy) busy_cnt = busy_cnt + 1;
            if (j != 4'b0 || k != 4'b0) begin
                if (drv_q.size() == 0) begin
                    chk("unexpected_drive", 32'({j, k}), 32'h0);
                end else begin
                    d = drv_q.pop_front();
                    chk("drive_j", 32'(j), 32'(d.j));
                    chk("drive_k", 32'(k), 32'(d.k));
                end
            end
            if (done || err) begin
                chk("done_err_exclusive", 32'(done & err), 32'h0);
                if (res_q.size() == 0) begin
                    chk("unexpected_result", 32'({done, err}), 32'h0);
                end else begin
                    r = res_q.pop_front();
                    chk("result_is_err", 32'(err), 32'(r.is_err));
                    chk("result_mismatch", 32'(mismatch), 32'(r.mism));
                    chk("result_latency", 32'(cyc - acc_cyc), 32'(r.lat));
                    chk("result_busy_cycles", 32'(busy_cnt), 32'(r.busy));
                end
            end
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                busy_cnt = 0;
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_bank(logic [3:0] v, logic [3:0] s);
        @(posedge clk);
        #1;
        bank_load = 1'b1;
        load_val = v;
        stuck = s;
        @(posedge clk);
        #1;
        bank_load = 1'b0;
    endtask

    task automatic expect_drive(logic [3:0] ej, logic [3:0] ek);
        drv_t d;
        d.j = ej;
        d.k = ek;
        drv_q.push_back(d);
    endtask

    task automatic expect_result(bit is_err, logic [3:0] mism, int lat, int bsy);
        res_t r;
        r.is_err = is_err;
        r.mism = mism;
        r.lat = lat;
        r.busy = bsy;
        res_q.push_back(r);
    endtask

    // Holds the request until accepted; returns at accept edge + 1
    task automatic send(logic [3:0] t);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_target = t;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_results();
        int n;
        n = 0;
        while ((res_q.size() != 0 || !req_ready) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("result_timeout", 32'(res_q.size()), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, held and after release
        tick(3);
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_jk", 32'({j, k}), 32'h0);
        chk("rst_done_err", 32'({done, err}), 32'h0);
        chk("rst_mismatch", 32'(mismatch), 32'h0);
        reset_n = 1'b1;
        tick(3);
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        chk("post_rst_outputs", 32'({busy, done, err, j, k, mismatch}), 32'h0);

        // Set/clear excitation: 0101 -> 0011
        load_bank(4'b0101, 4'b0000);
        expect_drive(TOG ? 4'b0110 : 4'b0010, TOG ? 4'b0110 : 4'b0100);
        expect_result(1'b0, 4'b0000, 5, 4);
        send(4'b0011);
        wait_results();
        chk("bank_after_setclr", 32'(q_fb), 32'h3);

        // Target equal to current state: no J/K pulse, still done
        load_bank(4'b0011, 4'b0000);
        expect_result(1'b0, 4'b0000, 5, 4);
        send(4'b0011);
        wait_results();

        // All bits change: 0011 -> 1100
        load_bank(4'b0011, 4'b0000);
        expect_drive(TOG ? 4'b1111 : 4'b1100, TOG ? 4'b1111 : 4'b0011);
        expect_result(1'b0, 4'b0000, 5, 4);
        send(4'b1100);
        wait_results();
        chk("bank_after_all_change", 32'(q_fb), 32'hc);

        // Stuck bit 2: two drive attempts then err
        load_bank(4'b0000, 4'b0100);
        expect_drive(4'b0100, TOG ? 4'b0100 : 4'b0000);
        expect_drive(4'b0100, TOG ? 4'b0100 : 4'b0000);
        expect_result(1'b1, 4'b0100, 9, 8);
        send(4'b0100);
        wait_results();
        tick(3);
        chk("mismatch_hold", 32'(mismatch), 32'h4);

        // Busy ignore, then back-to-back accept in the done cycle
        load_bank(4'b0000, 4'b0000);
        expect_drive(4'b0001, TOG ? 4'b0001 : 4'b0000);
        expect_result(1'b0, 4'b0000, 5, 4);
        send(4'b0001);
        tick(1);
        req_valid = 1'b1;
        req_target = 4'b1111;
        @(negedge clk);
        chk("ready_in_settle", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        expect_drive(4'b1000, TOG ? 4'b1000 : 4'b0000);
        expect_result(1'b0, 4'b0000, 5, 4);
        send(4'b1001);
        chk("b2b_drive_next_cycle", 32'(j), 32'h8);
        chk("b2b_busy", 32'(busy), 32'h1);
        wait_results();
        chk("bank_after_b2b", 32'(q_fb), 32'h9);

        // Reset during DRIVE: j/k clear without a clock edge, no result afterwards
        load_bank(4'b0000, 4'b0000);
        expect_drive(4'b1010, TOG ? 4'b1010 : 4'b0000);
        send(4'b1010);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_jk", 32'({j, k}), 32'h0);
        chk("midrst_ready_busy", 32'({req_ready, busy}), 32'h2);
        chk("midrst_done_err", 32'({done, err}), 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(10);
        chk("midrst_idle_ready", 32'(req_ready), 32'h1);
        chk("midrst_mismatch", 32'(mismatch), 32'h0);

        chk("drive_queue_empty", 32'(drv_q.size()), 32'h0);
        chk("result_queue_empty", 32'(res_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jk_drive_sequencer.md
Name: jk_drive_sequencer

Overview:
- Controller for the other end of the JK flip-flop interface: it generates the J/K excitation that drives a bank of W master-slave JK flip-flops.
- Accepts a target state over a valid/ready handshake and reads the bank's Q outputs back on q_fb.
- Derives per-bit J/K from the excitation table, pulses them, waits for the bank to settle, verifies the result and retries on mismatch.
- Sits between control logic and any JK register/counter bank in the lab designs.

Parameters:
- W, 4, number of flip-flops driven (target, q_fb, j, k width).
- SETTLE_CYCLES, 2, idle cycles after a drive pulse before q_fb is sampled; legal range 1..15.
- MAX_RETRY, 1, extra drive attempts after a failed check; legal range 0..7.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  target request valid.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_target  input  W  desired flip-flop bank state.
- q_fb  input  W  Q outputs fed back from the JK bank.
- j  output  W  J inputs to the bank.
- k  output  W  K inputs to the bank.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse: bank reached target.
- err  output  1  one-cycle pulse: retries exhausted, target not reached.
- mismatch  output  W  bits that differed (q_fb XOR target) at the final failed check.

Behaviour:
- Clock/reset (already decided): one clock, clk; reset_n is asynchronous, active-low.
- While reset_n is low:
  - state is IDLE; j, k, done, err and mismatch are 0; retry count and target register are 0.
  - req_ready=1 and busy=0.
- States: IDLE, DRIVE, SETTLE, CHECK.
- IDLE:
  - req_ready=1.
  - On a rising edge with req_valid=1, latch req_target, clear the retry count and go to DRIVE.
  - req_target is ignored while req_ready=0; there is no queueing.
- DRIVE:
  - Exactly one cycle. j/k are registered and equal the excitation of the latched target against q_fb as sampled at entry to DRIVE.
  - Next state is SETTLE.
- Excitation per bit (default build), as (q, t) -> (J, K):
  - (0, 0) -> (0, 0)
  - (0, 1) -> (1, 0)
  - (1, 0) -> (0, 1)
  - (1, 1) -> (0, 0)
  - Don't-cares resolve to 0, so a bit never sees J=K=1.
- SETTLE:
  - j=k=0.
  - Stays exactly SETTLE_CYCLES cycles (internal down-counter), then goes to CHECK.
- CHECK:
  - One cycle; compares q_fb to the target.
  - Equal: the next cycle returns to IDLE with done=1 for one cycle.
  - Unequal and retry count < MAX_RETRY: increment the retry count and go to DRIVE. Excitation is recomputed from the current q_fb.
  - Unequal and retries exhausted: return to IDLE with err=1 for one cycle; mismatch is loaded with q_fb XOR target.
- mismatch holds its value until the next accepted request, which clears it.
- done/err are asserted in the first IDLE cycle. req_ready is also high then, so a back-to-back request may be accepted in that same cycle.
- Latency, accept edge to done (success on first try): 1 (DRIVE) + SETTLE_CYCLES + 1 (CHECK) + 1 cycles. Default: 5 cycles.
- A target equal to the current q_fb still goes through DRIVE (j=k=0), SETTLE and CHECK, then done.
- Reset asserted mid-operation: j/k drop to 0 immediately (asynchronously), and any pending done/err is lost.
- done and err are never high together.

Optional Feature:
- Macro: JK_TOGGLE_DRIVE_EN.
- Defined: a bit whose value must change is driven J=K=1 (toggle); bits that hold are J=K=0. This exercises the bank's toggle mode.
- Undefined: the set/reset excitation above is used, and J=K=1 never appears on any bit.
- Handshake, timing, retry and error behaviour are identical in both builds.

Test Plan:
- Reset check: hold reset_n=0 -> req_ready=1, busy=0, j=k=0, done=err=0, mismatch=0. Release reset -> values unchanged until a request.
- Set/clear excitation: q_fb=4'b0101, request target 4'b0011, model bank follows J/K -> DRIVE cycle has j=4'b0010, k=4'b0100. done pulses 5 cycles after accept; busy is high for 4 cycles.
- Toggle build (JK_TOGGLE_DRIVE_EN defined): same stimulus as the set/clear case -> j=k=4'b0110 in DRIVE; done after 5 cycles.
- Stuck bit, MAX_RETRY=1: bit 2 of q_fb forced to 0, target 4'b0100 -> two DRIVE pulses with j=4'b0100, then err=1 one cycle, mismatch=4'b0100, done never asserted.
- Busy ignore and back-to-back: second req_valid during SETTLE is ignored (req_ready=0). A new request held valid through the done cycle is accepted on that cycle; DRIVE follows on the next cycle.
- Reset mid-operation: assert reset_n=0 during DRIVE -> j/k go to 0 without waiting for a clock edge; after release, IDLE with req_ready=1 and no done/err pulse.
